// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency/backpressure: not applicable (types and constants only).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int          CNT_W     = 4;
  localparam int          MAX_WAIT  = (1 << CNT_W) - 1;
  localparam logic [3:0]  MASK_READ = 4'b0000;

endpackage

// File: rtl/dmem_ram_bank.sv
// Four byte-wide synchronous RAM lanes: per-lane write enable, registered read on re_i.
// Read data appears the cycle after re_i; no backpressure (single-port, always ready).
module dmem_ram_bank #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            we_i,
  input  logic [31:0]           wdata_i,
  input  logic                  re_i,
  output logic [31:0]           rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (we_i[l]) begin
        mem_q[addr_i] <= wdata_i[8*l +: 8];
      end
      if (re_i) begin
        rd_q <= mem_q[addr_i];
      end
    end

    assign rdata_o[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: masked byte writes / whole-word reads, response 1+WAIT_CYCLES cycles after accept.
// req_ready drops while a response waits on resp_ready; DMEM_RANGE_CHECK_EN adds an address-window error check.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_write_data,
  input  logic [3:0]  req_write_mask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_load_data,
  output logic        resp_err
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES=%0d outside 0..%0d", WAIT_CYCLES, MAX_WAIT);
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_aw
    $error("dmem_responder: ADDR_WIDTH=%0d outside 1..30", ADDR_WIDTH);
  end

  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  resp_valid_q;
  logic                  resp_rd_q;
  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_win;
  logic                  is_write;
  logic                  accept;
  logic [3:0]            ram_we_d;
  logic                  ram_re_d;
  logic [31:0]           ram_rdata;

  assign req_ready = reset_n && ((state_q == IDLE) || (state_q == RESP && resp_ready));
  assign accept    = req_valid && req_ready;
  assign is_write  = (req_write_mask != MASK_READ);
  assign offset    = req_addr - BASE_ADDR;
  assign word_idx  = ADDR_WIDTH'(offset >> 2);

`ifdef DMEM_RANGE_CHECK_EN
  logic resp_err_q;
  // Unsigned offset makes addresses below BASE_ADDR wrap high and fail the test too.
  assign in_win   = ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
  assign resp_err = resp_err_q;
`else
  assign in_win   = 1'b1;
  assign resp_err = 1'b0;
`endif

  assign ram_we_d = (accept && is_write && in_win) ? req_write_mask : 4'b0000;
  assign ram_re_d = accept && !is_write && in_win;

  dmem_ram_bank #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (clk),
    .addr_i (word_idx),
    .we_i   (ram_we_d),
    .wdata_i(req_write_data),
    .re_i   (ram_re_d),
    .rdata_o(ram_rdata)
  );

  // RAM read register only moves on an accepted read, so it doubles as the held response word.
  assign resp_load_data = resp_rd_q ? ram_rdata : 32'd0;
  assign resp_valid     = resp_valid_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      resp_err_q   <= 1'b0;
`endif
    end else if (accept) begin
      resp_rd_q  <= ram_re_d;
`ifdef DMEM_RANGE_CHECK_EN
      resp_err_q <= !in_win;
`endif
      if (WAIT_CYCLES == 0) begin
        state_q      <= RESP;
        resp_valid_q <= 1'b1;
      end else begin
        state_q      <= WAIT;
        cnt_q        <= WAIT_LOAD;
        resp_valid_q <= 1'b0;
      end
    end else begin
      case (state_q)
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port. Accepts word-aligned requests carrying a byte write mask and write data already shifted into lane position by the load/store unit. Performs masked writes into an on-chip byte-lane RAM, or returns the full 32-bit word for reads. Sign extension and lane extraction remain in the core; this block always returns whole words. Sits between the core's load/store unit and on-chip data RAM.

## Interface
- `ADDR_WIDTH`, default 12: word-address bits; depth is 2^ADDR_WIDTH words (16 KiB).
- `WAIT_CYCLES`, default 0: extra response latency in cycles, 0..15.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept this cycle.
- `req_addr`  in  32  byte address; bits [1:0] ignored.
- `req_write_data`  in  32  lane-positioned store data.
- `req_write_mask`  in  4  byte enables; nonzero means write, 4'b0000 means read.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  core consumes the response.
- `resp_load_data`  out  32  read word; 0 for writes.
- `resp_err`  out  1  access error (see Configuration).

## Operation
- State machine states: IDLE, WAIT, RESP.
- Accept occurs when `req_valid && req_ready`.
- `req_ready` = (state==IDLE) || (state==RESP && `resp_ready`). It is forced to 0 while `reset_n` is low.
- On accept, the word index is `(req_addr - BASE_ADDR) >> 2`, truncated to ADDR_WIDTH bits.
- **Write:** byte lane i is updated iff `req_write_mask[i]`, committed at the accept edge. Unmasked lanes are untouched.
- **Read:** the RAM word is captured at the accept edge into the response register.
- A read accepted the cycle after a write to the same word returns the new data. No forwarding is needed.
- Transitions on accept:
  - WAIT_CYCLES==0: go to RESP.
  - Otherwise: go to WAIT, with the down-counter loaded with WAIT_CYCLES-1.
- WAIT decrements each cycle and goes to RESP when the counter is 0.
- RESP holds `resp_valid`=1, with `resp_load_data` and `resp_err` stable, until `resp_ready`.
- On `resp_ready` in RESP:
  - If a new request is accepted in the same cycle, proceed as for accept from IDLE.
  - Otherwise, go to IDLE.
- `resp_valid`=0 in IDLE and WAIT.

## Timing
- Reset values: state IDLE, `resp_valid`=0, `resp_load_data`=0, `resp_err`=0, wait counter 0. After `reset_n` rises, `req_ready`=1.
- RAM contents are not reset.
- Latency: `resp_valid` rises 1+WAIT_CYCLES cycles after the accept edge.
- Throughput with WAIT_CYCLES==0 and `resp_ready` held high: one transaction per cycle after the first.
- Backpressure: while `resp_ready`=0 in RESP, `req_ready`=0 and all response outputs hold.
- Reset mid-WAIT or mid-RESP: the pending response is dropped. `resp_valid`=0 on the cycle after the reset edge.
- Reset and writes: a write committed before the reset edge stays in RAM. A request presented during reset is not accepted and writes nothing.
- Counter is 4 bits. WAIT_CYCLES>15 is illegal and is flagged by an elaboration-time check.

## Configuration
- Macro: `DMEM_RANGE_CHECK_EN`.
- **Defined:** the block checks each accepted request against the window [BASE_ADDR, BASE_ADDR + 4·2^ADDR_WIDTH). A request outside the window:
  - performs no write;
  - returns `resp_load_data`=0 and `resp_err`=1;
  - keeps the same latency and handshake as a normal request.
- **Undefined:**
  - no range check is made;
  - addresses alias modulo the depth;
  - `resp_err` is constant 0.

## Structure
- Package `dmem_pkg` holds:
  - the state enum {IDLE, WAIT, RESP};
  - the wait-counter width constant (4);
  - the mask-encoded read constant 4'b0000.
- Sub-module `dmem_ram_bank`: four 8-bit-wide synchronous RAM lanes with per-lane write enable and registered read, depth 2^ADDR_WIDTH.
- The top level contains the FSM, counter, range check, and response register.

## Test plan
- Write 0xDEADBEEF, mask 4'b1111, to 0x10; then read 0x10 → `resp_load_data`=0xDEADBEEF, `resp_err`=0.
- Write 0x0000AB00 with mask 4'b0010 to 0x10; then read 0x10 → 0xDEADABEF.
- Read with `resp_ready` held low for 3 cycles → `resp_valid` high, data stable, `req_ready`=0. Release → IDLE next cycle.
- With WAIT_CYCLES=3, read accepted at cycle N → `resp_valid` first high at N+4.
- With WAIT_CYCLES=0, `resp_ready` high, 4 back-to-back reads of 0x0, 0x4, 0x8, 0xC → 4 responses on consecutive cycles, in order.
- Reset asserted while in RESP after a write → `resp_valid`=0 next cycle. A later read returns the written word.
- With `DMEM_RANGE_CHECK_EN`, BASE_ADDR=0: write to 0x0001_0000 → `resp_err`=1, and RAM word 0 is unchanged.
